// File: rtl/mult_seq_nxn.sv
// Sequential WIDTH x WIDTH multiplier built from a SLICE x SLICE digit multiplier.
// One digit partial product per cycle, shifted into place and accumulated; optional signed mode.
module mult_seq_nxn #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 reset_a,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic                 busy,
  output logic                 done_flag,
  output logic [2*WIDTH-1:0]   product
);

  localparam int D  = WIDTH / SLICE;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(D - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               state;
  state_t               next_state;
  logic                 accept;
  logic                 last_pp;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc;
  logic [DW-1:0]        di;
  logic [DW-1:0]        dj;

  logic [SLICE-1:0]     a_digit;
  logic [SLICE-1:0]     b_digit;
  logic [2*SLICE-1:0]   pp_raw;
  logic [2*WIDTH-1:0]   pp_shifted;

  // Magnitude of a possibly-signed operand; the most negative value maps to 2^(W-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             is_signed);
    return (is_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  assign last_pp = (di == LAST_DIGIT) && (dj == LAST_DIGIT);

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_pp) begin
          next_state = FIN;
        end
      end
      FIN: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // di walks the multiplicand digits fastest, dj the multiplier digits.
  always_comb begin
    a_digit    = a_mag[SLICE*int'(di) +: SLICE];
    b_digit    = b_mag[SLICE*int'(dj) +: SLICE];
    pp_raw     = {{SLICE{1'b0}}, a_digit} * {{SLICE{1'b0}}, b_digit};
    pp_shifted = (2*WIDTH)'(pp_raw) << (SLICE * (int'(di) + int'(dj)));
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      a_mag     <= '0;
      b_mag     <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      di        <= '0;
      dj        <= '0;
      product   <= '0;
      done_flag <= 1'b0;
    end else begin
      if (accept) begin
        a_mag     <= magnitude(dataa, signed_mode);
        b_mag     <= magnitude(datab, signed_mode);
        neg       <= signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
        acc       <= '0;
        di        <= '0;
        dj        <= '0;
        done_flag <= 1'b0;
      end else if (state == CALC) begin
        acc <= acc + pp_shifted;
        if (di == LAST_DIGIT) begin
          di <= '0;
          dj <= dj + 1'b1;
        end else begin
          di <= di + 1'b1;
        end
      end else if (state == FIN) begin
        product   <= neg ? (~acc + 1'b1) : acc;
        done_flag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mult_seq_nxn.md
Name: mult_seq_nxn

Overview:
Parametrised sequential N×N multiplier and the successor to the fixed 8×8 shift-and-add multiplier. Operands are split into SLICE-bit digits. Each cycle one digit-by-digit partial product is formed, shifted into position and accumulated. Adds a signed/unsigned mode select and a busy indicator, and rejects new starts while busy. It sits between operand registers and the display/result path of the arithmetic datapath.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of SLICE and ≥ SLICE.
SLICE, 4, digit width of the internal SLICE×SLICE multiplier.

Ports:
clk  input  1  system clock, rising-edge active.
reset_a  input  1  asynchronous active-low reset.
start  input  1  request; sampled on rising clk edge.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands.
dataa  input  WIDTH  multiplicand; captured on accepted start.
datab  input  WIDTH  multiplier; captured on accepted start.
busy  output  1  high while an operation is in progress.
done_flag  output  1  high while product holds a completed result.
product  output  2*WIDTH  result register.

Behaviour:
- Reset (reset_a=0, asynchronous, any state): state=IDLE; busy=0; done_flag=0; product=0; accumulator, digit counter, captured operands and sign all cleared. An in-flight operation is discarded.
- Derived constants: D = WIDTH/SLICE digits per operand; N = D*D partial-product cycles.
- FSM states: IDLE, CALC, FIN.
- IDLE, start=1 at an edge:
  - capture |dataa| and |datab|. In signed_mode, a negative operand is two's-complement negated; the magnitude fits in WIDTH bits unsigned, including the most negative value.
  - capture neg = signed_mode & (dataa[MSB] ^ datab[MSB]).
  - clear accumulator and counter; busy=1; done_flag=0; go to CALC.
  - product keeps its previous value until FIN.
- CALC, one edge per counter value k = 0..N-1:
  - i = k mod D, j = k div D.
  - acc += (a_digit[i] * b_digit[j]) << (SLICE*(i+j)).
  - accumulator is 2*WIDTH bits and never overflows.
  - after the k=N-1 edge, go to FIN.
- FIN, single edge: product = neg ? -acc : acc (2*WIDTH-bit two's complement); done_flag=1; busy=0; go to IDLE.
- Latency: the start edge is edge 0; product and done_flag are valid after edge N+1. Default 8/4: N=4, result after 5 edges.
- done_flag stays high until the next accepted start, which clears it at that edge.
- start while busy (CALC or FIN) is ignored; dataa/datab/signed_mode changes during an operation have no effect.
- start held high continuously: a new operation is accepted on the first IDLE edge after FIN. The done_flag=1 window then lasts 1 cycle.
- Unsigned mode: a result of 0 is valid; done_flag still asserts.
- Signed extremes: -2^(W-1) × -2^(W-1) = +2^(2W-2); representable, no saturation.

Test Plan:
- Unsigned 8/4: reset_a low→high, dataa=50, datab=10, start 1 cycle → busy 1 for 5 edges; after edge 5 product=0x01F4, done_flag=1, busy=0.
- Unsigned max: dataa=0xFF, datab=0xFF, signed_mode=0 → product=0xFE01. Then dataa=0x10, datab=0x50 → product=0x0500, with done_flag low from the start edge until edge 5.
- Signed: (-3)×5 → 0xFFF1; (-128)×(-128) → 0x4000; (-128)×127 → 0xC080; 0×(-1) → 0x0000.
- Busy rejection: during CALC pulse start with different dataa/datab → first result unchanged, no second operation; busy falls exactly once.
- Reset mid-operation: assert reset_a at edge 2 of CALC (asynchronously, between edges) → busy, done_flag and product go to 0 immediately. After release, a fresh 7×3 gives 21 after 5 edges.
- Parameter instance WIDTH=16, SLICE=4: 0xFFFF×0xFFFF unsigned → 0xFFFE0001 after 17 edges; signed 0x8000×0x8000 → 0x40000000.
